// File: rtl/sprite_layer.sv
// sprite_layer: composites NUM_SPRITES ROM-backed sprites over a vga_bus stream.
// Sprite state is latched at vblank so frames never tear; sprite overlaps are reported per frame.
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 40
`endif

module sprite_layer #(
  parameter int unsigned NUM_SPRITES = 2,
  parameter int unsigned SPR_W       = 64,
  parameter int unsigned SPR_H       = 64,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned ROM_LAT     = 1,
  parameter logic [11:0] KEY_COLOR   = 12'h000
) (
  input  logic                          pclk,
  input  logic                          rst,
  input  logic [`VGA_BUS_SIZE-1:0]      vga_in,
  output logic [`VGA_BUS_SIZE-1:0]      vga_out,
  input  logic [12*NUM_SPRITES-1:0]     xpos,
  input  logic [12*NUM_SPRITES-1:0]     ypos,
  input  logic [NUM_SPRITES-1:0]        enable,
  input  logic [NUM_SPRITES-1:0]        mirror,
  output logic [ADDR_W*NUM_SPRITES-1:0] rom_addr,
  input  logic [12*NUM_SPRITES-1:0]     rom_pixel,
  output logic [NUM_SPRITES-1:0]        coll,
  output logic                          coll_valid
);

  // Bus layout: {hcount[11:0], vcount[11:0], hsync, vsync, hblnk, vblnk, rgb[11:0]}.
  localparam int unsigned BusW      = `VGA_BUS_SIZE;
  localparam int unsigned HcountLsb = 28;
  localparam int unsigned VcountLsb = 16;
  localparam int unsigned HblnkBit  = 13;
  localparam int unsigned VblnkBit  = 12;
  localparam int unsigned LogW      = $clog2(SPR_W);
  localparam logic [12:0] SprW13    = 13'(SPR_W);
  localparam logic [12:0] SprH13    = 13'(SPR_H);

  if (NUM_SPRITES < 1 || NUM_SPRITES > 8 || ROM_LAT < 1 || ROM_LAT > 3 ||
      (1 << LogW) != SPR_W || (2 ** ADDR_W) < SPR_W * SPR_H) begin : g_bad_params
    $error("sprite_layer: illegal parameter combination");
  end

  // Shadow copies of the sprite controls, refreshed only at the start of vblank.
  logic [12*NUM_SPRITES-1:0] x_sh_q, y_sh_q;
  logic [NUM_SPRITES-1:0]    en_sh_q, mir_sh_q;
  logic                      vblnk_in_q;
  logic                      vblnk_rise_in;

  assign vblnk_rise_in = vga_in[VblnkBit] & ~vblnk_in_q;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      vblnk_in_q <= 1'b0;
      x_sh_q     <= '0;
      y_sh_q     <= '0;
      en_sh_q    <= '0;
      mir_sh_q   <= '0;
    end else begin
      vblnk_in_q <= vga_in[VblnkBit];
      if (vblnk_rise_in) begin
        x_sh_q   <= xpos;
        y_sh_q   <= ypos;
        en_sh_q  <= enable;
        mir_sh_q <= mirror;
      end
    end
  end

  // Stage 1 hit test and address generation, 13 bits wide so x+SPR_W never wraps.
  logic [11:0]                   h_in, v_in;
  logic [NUM_SPRITES-1:0]        hit_d;
  logic [ADDR_W*NUM_SPRITES-1:0] addr_d;

  assign h_in = vga_in[HcountLsb +: 12];
  assign v_in = vga_in[VcountLsb +: 12];

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
    logic [12:0]       x13, y13, h13, v13, rel_x, rel_y, col;
    logic [ADDR_W-1:0] lin;
    logic              in_x, in_y;

    assign x13   = {1'b0, x_sh_q[12*i +: 12]};
    assign y13   = {1'b0, y_sh_q[12*i +: 12]};
    assign h13   = {1'b0, h_in};
    assign v13   = {1'b0, v_in};
    assign in_x  = (h13 >= x13) && (h13 < x13 + SprW13);
    assign in_y  = (v13 >= y13) && (v13 < y13 + SprH13);
    assign rel_x = h13 - x13;
    assign rel_y = v13 - y13;
    assign col   = mir_sh_q[i] ? (SprW13 - 13'd1 - rel_x) : rel_x;
    assign lin   = ADDR_W'({13'd0, rel_y} << LogW) + ADDR_W'(col);

    assign hit_d[i] = en_sh_q[i] & ~vga_in[HblnkBit] & ~vga_in[VblnkBit] & in_x & in_y;
    assign addr_d[ADDR_W*i +: ADDR_W] = hit_d[i] ? lin : '0;
  end

  // Delay line: index 0 is stage 1, index ROM_LAT lines up with rom_pixel.
  logic [BusW-1:0]        bus_q [ROM_LAT+1];
  logic [NUM_SPRITES-1:0] hit_q [ROM_LAT+1];

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      rom_addr <= '0;
      for (int k = 0; k <= int'(ROM_LAT); k++) begin
        bus_q[k] <= '0;
        hit_q[k] <= '0;
      end
    end else begin
      rom_addr <= addr_d;
      bus_q[0] <= vga_in;
      hit_q[0] <= hit_d;
      for (int k = 1; k <= int'(ROM_LAT); k++) begin
        bus_q[k] <= bus_q[k-1];
        hit_q[k] <= hit_q[k-1];
      end
    end
  end

  // Output stage: priority composite and collision accumulation.
  logic [BusW-1:0]        bus_al;
  logic [NUM_SPRITES-1:0] hit_al, opaque, multi_hits;
  logic [NUM_SPRITES-1:0] acc_q, acc_d, coll_d;
  logic [11:0]            rgb_d;
  logic                   multi, vblnk_rise_out, cv_d;

  assign bus_al = bus_q[ROM_LAT];
  assign hit_al = hit_q[ROM_LAT];

  always_comb begin
    opaque = '0;
    for (int i = 0; i < int'(NUM_SPRITES); i++) begin
      opaque[i] = hit_al[i] & (rom_pixel[12*i +: 12] != KEY_COLOR);
    end
  end

  // Walk from lowest priority up so sprite 0 wins.
  always_comb begin
    rgb_d = bus_al[11:0];
    for (int i = int'(NUM_SPRITES) - 1; i >= 0; i--) begin
      if (opaque[i]) rgb_d = rom_pixel[12*i +: 12];
    end
  end

  assign multi          = |(opaque & (opaque - NUM_SPRITES'(1)));
  assign multi_hits     = multi ? opaque : '0;
  assign vblnk_rise_out = bus_al[VblnkBit] & ~vga_out[VblnkBit];

  always_comb begin
    acc_d  = acc_q | multi_hits;
    coll_d = coll;
    cv_d   = 1'b0;
    if (vblnk_rise_out) begin
      coll_d = acc_d;
      acc_d  = '0;
      cv_d   = 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      vga_out    <= '0;
      acc_q      <= '0;
      coll       <= '0;
      coll_valid <= 1'b0;
    end else begin
      vga_out    <= {bus_al[BusW-1:12], rgb_d};
      acc_q      <= acc_d;
      coll       <= coll_d;
      coll_valid <= cv_d;
    end
  end

endmodule

// File: tb/tb_sprite_layer.sv
// Bench for sprite_layer: table-driven pixel probes with a latency-aware scoreboard,
// plus hand sequences for frame latching, collisions and asynchronous reset.
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 40
`endif

module tb_sprite_layer;

  localparam logic [11:0] BG = 12'h00A;
  localparam int Lat = 3;

  logic        pclk = 1'b0;
  logic        rst;
  logic [39:0] vga_in, vga_out;
  logic [23:0] xpos, ypos;
  logic [1:0]  enable, mirror;
  logic [23:0] rom_addr, rom_pixel;
  logic [1:0]  coll;
  logic        coll_valid;

  always #5 pclk = ~pclk;

  sprite_layer dut (
    .pclk       (pclk),
    .rst        (rst),
    .vga_in     (vga_in),
    .vga_out    (vga_out),
    .xpos       (xpos),
    .ypos       (ypos),
    .enable     (enable),
    .mirror     (mirror),
    .rom_addr   (rom_addr),
    .rom_pixel  (rom_pixel),
    .coll       (coll),
    .coll_valid (coll_valid)
  );

  // ROM model: one-cycle registered read; either flat colour or the address itself.
  logic [11:0] col0, col1;
  logic        pat;

  function automatic logic [11:0] rom_f(input int i, input logic [11:0] a);
    if (pat) return a;
    return (i == 0) ? col0 : col1;
  endfunction

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) rom_pixel <= '0;
    else begin
      rom_pixel[11:0]  <= rom_f(0, rom_addr[11:0]);
      rom_pixel[23:12] <= rom_f(1, rom_addr[23:12]);
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [39:0] bus;
    logic [1:0]  coll;
    logic        cv;
    int          due;
  } sb_t;

  typedef struct {
    logic [11:0] h;
    logic [11:0] v;
    logic [11:0] rgb_exp;
    logic        chk_addr;
    logic [11:0] addr_exp;
  } vec_t;

  sb_t  sb[$];
  vec_t tv[$];
  sb_t  mon_e;
  logic [1:0] cur_coll;

  always @(negedge pclk) begin
    if (rst && sb.size() > 0) begin
      if (sb[0].due < cyc) begin
        mon_e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_output: due cycle %0d not seen, now %0d", mon_e.due, cyc);
      end else if (sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        check("vga_out", 64'(vga_out), 64'(mon_e.bus));
        check("coll", 64'(coll), 64'(mon_e.coll));
        check("coll_valid", 64'(coll_valid), 64'(mon_e.cv));
      end
    end
  end

  task automatic pix(input logic [11:0] h, input logic [11:0] v, input logic hb,
                     input logic vb, input logic [11:0] rgb_exp, input logic cv);
    sb_t e;
    vga_in = {h, v, h[0], v[0], hb, vb, BG};
    e.bus  = {h, v, h[0], v[0], hb, vb, rgb_exp};
    e.coll = cur_coll;
    e.cv   = cv;
    e.due  = cyc + Lat;
    sb.push_back(e);
    @(posedge pclk);
    #1;
  endtask

  // Blanked lead-in, vblnk rise (latches controls and reports collisions), lead-out.
  task automatic latch(input logic [1:0] exp_coll);
    pix(12'd0, 12'd0, 1'b1, 1'b0, BG, 1'b0);
    pix(12'd0, 12'd0, 1'b1, 1'b0, BG, 1'b0);
    cur_coll = exp_coll;
    pix(12'd0, 12'd768, 1'b1, 1'b1, BG, 1'b1);
    pix(12'd1, 12'd768, 1'b1, 1'b1, BG, 1'b0);
    pix(12'd0, 12'd0, 1'b1, 1'b0, BG, 1'b0);
  endtask

  function automatic vec_t mk(input int h, input int v, input logic [11:0] rgb,
                              input logic chk = 1'b0, input int addr = 0);
    vec_t t;
    t.h = 12'(h);
    t.v = 12'(v);
    t.rgb_exp = rgb;
    t.chk_addr = chk;
    t.addr_exp = 12'(addr);
    return t;
  endfunction

  task automatic drain();
    for (int n = 0; n < 20 && sb.size() > 0; n++) @(posedge pclk);
    #1;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d outputs never arrived", sb.size());
      sb.delete();
    end
  endtask

  task automatic apply();
    for (int i = 0; i < tv.size(); i++) begin
      pix(tv[i].h, tv[i].v, 1'b0, 1'b0, tv[i].rgb_exp, 1'b0);
      if (tv[i].chk_addr) check("rom_addr0", 64'(rom_addr[11:0]), 64'(tv[i].addr_exp));
    end
    tv.delete();
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; vga_in = '0; xpos = '0; ypos = '0; enable = '0; mirror = '0;
    col0 = 12'hF00; col1 = 12'h0F0; pat = 1'b0; cur_coll = 2'b00;
    #22;
    check("reset_vga_out", 64'(vga_out), 64'd0);
    check("reset_rom_addr", 64'(rom_addr), 64'd0);
    check("reset_coll", 64'(coll), 64'd0);
    check("reset_coll_valid", 64'(coll_valid), 64'd0);
    @(posedge pclk); #1;
    rst = 1'b1;

    // Single opaque sprite at (100,200).
    xpos = {12'd0, 12'd100}; ypos = {12'd0, 12'd200}; enable = 2'b01;
    latch(2'b00);
    tv.push_back(mk(99, 200, BG));   tv.push_back(mk(100, 200, 12'hF00));
    tv.push_back(mk(163, 200, 12'hF00)); tv.push_back(mk(164, 200, BG));
    tv.push_back(mk(100, 199, BG));  tv.push_back(mk(130, 263, 12'hF00));
    tv.push_back(mk(130, 264, BG));  tv.push_back(mk(163, 263, 12'hF00));
    apply();

    // Mirrored, ROM returns its address: column order reverses.
    mirror = 2'b01; pat = 1'b1;
    latch(2'b00);
    tv.push_back(mk(100, 200, 12'h03F, 1'b1, 63));
    tv.push_back(mk(101, 200, 12'h03E, 1'b1, 62));
    tv.push_back(mk(163, 200, BG, 1'b1, 0));
    tv.push_back(mk(100, 201, 12'h07F, 1'b1, 127));
    tv.push_back(mk(99, 200, BG, 1'b1, 0));
    apply();

    // Two overlapping opaque sprites: sprite 0 wins, collision reported next vblnk.
    mirror = 2'b00; pat = 1'b0; enable = 2'b11;
    xpos = {12'd120, 12'd100}; ypos = {12'd210, 12'd200};
    latch(2'b00);
    tv.push_back(mk(110, 205, 12'hF00)); tv.push_back(mk(130, 215, 12'hF00));
    tv.push_back(mk(170, 215, 12'h0F0)); tv.push_back(mk(180, 280, BG));
    tv.push_back(mk(120, 210, 12'hF00));
    apply();
    xpos = {12'd300, 12'd100};
    latch(2'b11);
    tv.push_back(mk(130, 215, 12'hF00)); tv.push_back(mk(310, 215, 12'h0F0));
    apply();
    latch(2'b00);

    // Sprite 0 fully transparent over sprite 1: no collision.
    xpos = {12'd120, 12'd100}; col0 = 12'h000;
    latch(2'b00);
    tv.push_back(mk(130, 215, 12'h0F0)); tv.push_back(mk(110, 205, BG));
    apply();
    latch(2'b00);

    // Mid-frame position change is deferred; disabled sprite never draws.
    col0 = 12'hF00; enable = 2'b01;
    latch(2'b00);
    xpos[11:0] = 12'd300;
    tv.push_back(mk(100, 200, 12'hF00)); tv.push_back(mk(300, 200, BG));
    apply();
    latch(2'b00);
    tv.push_back(mk(100, 200, BG)); tv.push_back(mk(300, 200, 12'hF00));
    tv.push_back(mk(130, 215, BG));
    apply();

    // Right-edge sprite must not wrap; sprite 1 at x=0.
    xpos = {12'd0, 12'd4090}; ypos = {12'd0, 12'd200}; enable = 2'b11;
    latch(2'b00);
    tv.push_back(mk(4089, 200, BG)); tv.push_back(mk(4090, 200, 12'hF00));
    tv.push_back(mk(4095, 200, 12'hF00)); tv.push_back(mk(5, 200, BG));
    tv.push_back(mk(0, 5, 12'h0F0)); tv.push_back(mk(63, 5, 12'h0F0));
    tv.push_back(mk(64, 5, BG));
    apply();

    // Asynchronous reset mid-line.
    pix(12'd4090, 12'd200, 1'b0, 1'b0, 12'hF00, 1'b0);
    sb.delete();
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_vga_out", 64'(vga_out), 64'd0);
    check("async_rst_rom_addr", 64'(rom_addr), 64'd0);
    check("async_rst_coll", 64'(coll), 64'd0);
    check("async_rst_coll_valid", 64'(coll_valid), 64'd0);
    @(posedge pclk); @(posedge pclk); #1;
    rst = 1'b1;
    cur_coll = 2'b00;
    tv.push_back(mk(4090, 200, BG)); tv.push_back(mk(10, 5, BG));
    apply();
    latch(2'b00);
    tv.push_back(mk(4090, 200, 12'hF00)); tv.push_back(mk(10, 5, 12'h0F0));
    apply();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
